// File: rtl/ctrl_ramdrv_smpseq_pkg.sv
// ctrl_ramdrv_smpseq_pkg
//   Shared definitions for the sample write / tap-read sequencer.
//   - state_t     : sequencer FSM encoding (3 bits)
//   - cmd values  : {init, cnt} command pairs understood by the ring buffer
//                   address counter; the encoding keeps init and cnt exclusive.
package ctrl_ramdrv_smpseq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    INIT  = 3'd2,
    PRIME = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // {rb_init, rb_cnt}
  localparam logic [1:0] INIT_BUFFER = 2'b10;
  localparam logic [1:0] PROC_BUFFER = 2'b01;
  localparam logic [1:0] SLEEP       = 2'b00;

endpackage

// File: rtl/ctrl_ramdrv_smpseq_if.sv
// ctrl_ramdrv_smpseq_if
//   Bundles the sequencer's config, sample handshake, RAM port, counter port
//   and MAC framing signals.
//   master : the sequencer (drives RAM strobes, counter commands, framing)
//   slave  : the surrounding system (config source, sample source, RAM,
//            ring buffer counter, MAC)
interface ctrl_ramdrv_smpseq_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  import ctrl_ramdrv_smpseq_pkg::*;

  // segment configuration
  logic                  cfg_load;
  logic [ADDR_WIDTH-1:0] cfg_bptr;
  logic [ADDR_WIDTH-1:0] cfg_lptr;
  logic                  cfg_err;
  // sample handshake
  logic                  smp_valid;
  logic [DATA_WIDTH-1:0] smp_data;
  logic                  smp_ready;
  // RAM
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  // ring buffer counter
  logic                  rb_init;
  logic                  rb_cnt;
  logic [ADDR_WIDTH-1:0] rb_hptr;
  logic [ADDR_WIDTH-1:0] rb_bptr;
  logic [ADDR_WIDTH-1:0] rb_lptr;
  logic [ADDR_WIDTH-1:0] rb_addr;
  logic                  rb_fin;
  // MAC framing / status
  logic                  acc_start;
  logic                  acc_last;
  logic                  done;
  logic                  busy;

  modport master (
    input  cfg_load, cfg_bptr, cfg_lptr, smp_valid, smp_data, rb_addr, rb_fin,
    output cfg_err, smp_ready, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
           rb_init, rb_cnt, rb_hptr, rb_bptr, rb_lptr,
           acc_start, acc_last, done, busy
  );

  modport slave (
    output cfg_load, cfg_bptr, cfg_lptr, smp_valid, smp_data, rb_addr, rb_fin,
    input  cfg_err, smp_ready, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
           rb_init, rb_cnt, rb_hptr, rb_bptr, rb_lptr,
           acc_start, acc_last, done, busy
  );

endinterface

// File: rtl/ctrl_ramdrv_headptr.sv
// ctrl_ramdrv_headptr
//   Segment config registers, ring buffer head pointer and the sticky error
//   flag. All state updates on the falling clock edge.
//   Ports:
//     clk, clr          : clock (falling edge), synchronous active-high reset
//     cfg_load          : config load request
//     cfg_bptr/cfg_lptr : requested segment base / upper address
//     idle              : sequencer is in IDLE (config may be taken)
//     adv               : sample accepted, advance head to the next cell
//     err_set           : external error event (read safety bound hit)
//     head, bptr, lptr  : registered head and segment bounds
//     cfg_valid         : a legal segment has been loaded since reset
//     cfg_err           : sticky error, cleared only by clr
module ctrl_ramdrv_headptr
  import ctrl_ramdrv_smpseq_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cfg_load,
  input  logic [ADDR_WIDTH-1:0] cfg_bptr,
  input  logic [ADDR_WIDTH-1:0] cfg_lptr,
  input  logic                  idle,
  input  logic                  adv,
  input  logic                  err_set,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH-1:0] bptr,
  output logic [ADDR_WIDTH-1:0] lptr,
  output logic                  cfg_valid,
  output logic                  cfg_err
);

  // Wrap from the upper address straight back to the base; the increment is
  // only taken below lptr, so it can never carry out of ADDR_WIDTH bits.
  function automatic logic [ADDR_WIDTH-1:0] ring_next(
    input logic [ADDR_WIDTH-1:0] h,
    input logic [ADDR_WIDTH-1:0] b,
    input logic [ADDR_WIDTH-1:0] l
  );
    return (h == l) ? b : h + ADDR_WIDTH'(1);
  endfunction

  always_ff @(negedge clk) begin
    if (clr) begin
      head      <= '0;
      bptr      <= '0;
      lptr      <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (cfg_load) begin
        if (!idle) begin
          cfg_err <= 1'b1;
        end else if (cfg_lptr >= cfg_bptr) begin
          bptr      <= cfg_bptr;
          lptr      <= cfg_lptr;
          // Parking head on lptr makes the first accepted sample land on bptr.
          head      <= cfg_lptr;
          cfg_valid <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      // adv implies !cfg_load, so it never collides with a config load.
      if (adv) begin
        head <= ring_next(head, bptr, lptr);
      end
      if (err_set) begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_ramdrv_smpseq.sv
// ctrl_ramdrv_smpseq
//   Sample write and tap-read sequencer in front of the ring buffer address
//   counter. Each accepted sample advances the head, is written to RAM at the
//   new head, and is followed by one RAM read per tap (newest to oldest)
//   addressed by the counter, framed with acc_start/acc_last for the MAC.
//   Ports:
//     clk  : clock; all state updates on the falling edge (counter timing)
//     clr  : synchronous active-high reset
//     sif  : master side of ctrl_ramdrv_smpseq_if (config, sample handshake,
//            RAM port, counter init/cnt/pointers, MAC framing, status)
//   Sequence per sample: WRITE, INIT, PRIME, READ x N, DONE  (N+4 cycles).
module ctrl_ramdrv_smpseq
  import ctrl_ramdrv_smpseq_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input logic                  clk,
  input logic                  clr,
  ctrl_ramdrv_smpseq_if.master sif
);

  state_t                state;
  logic [1:0]            cmd;
  logic                  ram_we_q;
  logic                  ram_re_q;
  logic                  acc_start_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [DATA_WIDTH-1:0] smp_q;

  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] bptr;
  logic [ADDR_WIDTH-1:0] lptr;
  logic [ADDR_WIDTH-1:0] span;
  logic                  cfg_valid;
  logic                  cfg_err;
  logic                  idle;
  logic                  ready;
  logic                  accept;
  logic                  rd_timeout;

  assign idle   = (state == IDLE);
  assign ready  = idle && cfg_valid && !sif.cfg_load;
  assign accept = sif.smp_valid && ready;

  // span = N-1; kept in ADDR_WIDTH bits so a full-range segment cannot overflow.
  assign span       = lptr - bptr;
  assign rd_timeout = (state == READ) && !sif.rb_fin && (rd_cnt == span);

  ctrl_ramdrv_headptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_headptr (
    .clk       (clk),
    .clr       (clr),
    .cfg_load  (sif.cfg_load),
    .cfg_bptr  (sif.cfg_bptr),
    .cfg_lptr  (sif.cfg_lptr),
    .idle      (idle),
    .adv       (accept),
    .err_set   (rd_timeout),
    .head      (head),
    .bptr      (bptr),
    .lptr      (lptr),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err)
  );

  // Sample holding register: data path, no reset.
  always_ff @(negedge clk) begin
    if (accept) begin
      smp_q <= sif.smp_data;
    end
  end

  always_ff @(negedge clk) begin
    if (clr) begin
      state       <= IDLE;
      cmd         <= SLEEP;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      acc_start_q <= 1'b0;
      done_q      <= 1'b0;
      rd_cnt      <= '0;
    end else begin
      ram_we_q    <= 1'b0;
      acc_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= WRITE;
            ram_we_q <= 1'b1;
          end
        end
        WRITE: begin
          state <= INIT;
          cmd   <= INIT_BUFFER;
        end
        INIT: begin
          state <= PRIME;
          cmd   <= PROC_BUFFER;
        end
        // The counter spends this cycle on its first cell; reads start next.
        PRIME: begin
          state       <= READ;
          ram_re_q    <= 1'b1;
          acc_start_q <= 1'b1;
          rd_cnt      <= '0;
        end
        // Leave on the counter's finish flag, or after N reads if it never comes.
        READ: begin
          if (sif.rb_fin || (rd_cnt == span)) begin
            state    <= DONE;
            ram_re_q <= 1'b0;
            cmd      <= SLEEP;
            done_q   <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          cmd      <= SLEEP;
          ram_re_q <= 1'b0;
        end
      endcase
    end
  end

  assign sif.smp_ready = ready;
  assign sif.cfg_err   = cfg_err;
  assign sif.busy      = !idle;

  assign sif.ram_we    = ram_we_q;
  assign sif.ram_waddr = head;
  assign sif.ram_wdata = ram_we_q ? smp_q : '0;
  assign sif.ram_re    = ram_re_q;
  assign sif.ram_raddr = ram_re_q ? sif.rb_addr : '0;

  assign {sif.rb_init, sif.rb_cnt} = cmd;
  assign sif.rb_hptr   = head;
  assign sif.rb_bptr   = bptr;
  assign sif.rb_lptr   = lptr;

  assign sif.acc_start = acc_start_q;
  // The counter's finish flag marks the oldest tap in the same cycle.
  assign sif.acc_last  = ram_re_q && sif.rb_fin;
  assign sif.done      = done_q;

endmodule
